// File: rtl/tt_reshape_pkg.sv
// tt_reshape_pkg
//   Shared definitions for the reshape gather buffer and its bank storage.
//   Provides the default matrix geometry (X_WIDTH elements of Y_WIDTH bits,
//   LANES elements per input beat), derived beat/count widths, the bank
//   select type and a helper that sizes index fields safely for a count of 1.
package tt_reshape_pkg;

    localparam int DEF_X_WIDTH = 32;
    localparam int DEF_Y_WIDTH = 4;
    localparam int DEF_LANES   = 8;
    localparam int DEF_BEATS   = DEF_X_WIDTH / DEF_LANES;
    localparam int DEF_CNT_W   = $clog2(DEF_X_WIDTH + 1);

    // One bit selects between the two ping-pong banks.
    typedef logic bank_sel_t;

    // Width of an index into n items; never zero so a 1-beat matrix still
    // gets a legal (constant zero) beat counter.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_reshape_gather_bank.sv
// tt_reshape_gather_bank
//   Storage for one X_WIDTH x Y_WIDTH matrix, written one beat (LANES
//   elements) at a time.
//   Ports:
//     clk, reset    clock, synchronous active-high reset (clears storage)
//     we            write this beat into the bank
//     beat_idx      which LANES-element slice the beat lands in
//     lanes         beat data, element l at [l*Y_WIDTH +: Y_WIDTH]
//     clear_others  zero every slice other than beat_idx during this write
//     data          whole matrix, element e at [e*Y_WIDTH +: Y_WIDTH]
module tt_reshape_gather_bank
    import tt_reshape_pkg::*;
#(
    parameter int X_WIDTH = DEF_X_WIDTH,
    parameter int Y_WIDTH = DEF_Y_WIDTH,
    parameter int LANES   = DEF_LANES,
    parameter int BI_W    = idx_width(X_WIDTH / LANES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [BI_W-1:0]            beat_idx,
    input  logic [LANES*Y_WIDTH-1:0]   lanes,
    input  logic                       clear_others,
    output logic [X_WIDTH*Y_WIDTH-1:0] data
);

    localparam int BEATS = X_WIDTH / LANES;
    localparam int SEG_W = LANES * Y_WIDTH;

    // Storage is organised as BEATS slices; the first beat of a matrix
    // wipes the stale slices so an early-closed matrix reads zero above
    // its last written element.
    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (we) begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_idx == BI_W'(b)) begin
                    data[b*SEG_W +: SEG_W] <= lanes;
                end else if (clear_others) begin
                    data[b*SEG_W +: SEG_W] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/tt_reshape_gather.sv
// tt_reshape_gather
//   Ping-pong gather buffer feeding the XY->YX reshape stage. Beats of LANES
//   Y_WIDTH-bit elements are assembled into a full X_WIDTH-element matrix,
//   which is then offered downstream while the other bank fills.
//   Ports:
//     i_clk, i_reset  clock, synchronous active-high reset
//     i_valid/o_ready input beat handshake; i_rows beat data, i_last closes
//                     the matrix early
//     o_valid/i_ready matrix handshake; o_xy_signal matrix (element e at
//                     [e*Y_WIDTH +: Y_WIDTH]), o_count elements written
//     i_flush         only when TT_RESHAPE_GATHER_FLUSH_EN is defined:
//                     drops pending matrices and any beat in that cycle
//   Handshakes: a transfer happens on a rising edge where valid && ready.
//   The sender holds valid and its payload stable until that edge; ready
//   here is derived from registered state only and never looks at valid.
module tt_reshape_gather
    import tt_reshape_pkg::*;
#(
    parameter int X_WIDTH = DEF_X_WIDTH,
    parameter int Y_WIDTH = DEF_Y_WIDTH,
    parameter int LANES   = DEF_LANES
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic [LANES*Y_WIDTH-1:0]       i_rows,
    input  logic                           i_last,
`ifdef TT_RESHAPE_GATHER_FLUSH_EN
    input  logic                           i_flush,
`endif
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [X_WIDTH*Y_WIDTH-1:0]     o_xy_signal,
    output logic [$clog2(X_WIDTH+1)-1:0]   o_count
);

    localparam int BEATS = X_WIDTH / LANES;
    localparam int BI_W  = idx_width(BEATS);
    localparam int CNT_W = $clog2(X_WIDTH + 1);
    localparam int MW    = X_WIDTH * Y_WIDTH;

    logic [1:0]       full;
    bank_sel_t        wr_bank;
    bank_sel_t        rd_bank;
    logic [BI_W-1:0]  beat_idx;
    logic [CNT_W-1:0] cnt [2];
    logic [MW-1:0]    bank_data [2];

    logic             flush;
    logic             accept;
    logic             close;
    logic             drain;
    logic [CNT_W-1:0] close_cnt;

`ifdef TT_RESHAPE_GATHER_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign o_ready   = !full[wr_bank] && !i_reset;
    // A beat accepted alongside a flush is discarded.
    assign accept    = i_valid && o_ready && !flush;
    assign close     = i_last || (beat_idx == BI_W'(BEATS - 1));
    assign drain     = full[rd_bank] && i_ready;
    assign close_cnt = CNT_W'((int'(beat_idx) + 1) * LANES);

    assign o_valid     = full[rd_bank];
    assign o_xy_signal = bank_data[rd_bank];
    assign o_count     = cnt[rd_bank];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        tt_reshape_gather_bank #(
            .X_WIDTH (X_WIDTH),
            .Y_WIDTH (Y_WIDTH),
            .LANES   (LANES),
            .BI_W    (BI_W)
        ) u_bank (
            .clk          (i_clk),
            .reset        (i_reset),
            .we           (accept && (wr_bank == bank_sel_t'(g))),
            .beat_idx     (beat_idx),
            .lanes        (i_rows),
            .clear_others (beat_idx == '0),
            .data         (bank_data[g])
        );
    end

    // A write never targets a full bank, so when a close and a drain happen
    // in the same cycle they always touch different full bits.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            beat_idx <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else if (flush) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            beat_idx <= '0;
        end else begin
            if (accept) begin
                if (close) begin
                    full[wr_bank] <= 1'b1;
                    cnt[wr_bank]  <= close_cnt;
                    wr_bank       <= ~wr_bank;
                    beat_idx      <= '0;
                end else begin
                    beat_idx <= beat_idx + BI_W'(1);
                end
            end
            if (drain) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

`ifdef SIM
`ifndef DISABLE_ASSERTIONS
    logic                     chk_stall;
    logic [LANES*Y_WIDTH-1:0] chk_rows;
    logic                     chk_last;

    always_ff @(posedge i_clk) begin
        chk_stall <= i_valid && !o_ready && !i_reset;
        chk_rows  <= i_rows;
        chk_last  <= i_last;
        if (!i_reset) begin
            a_geom: assert (X_WIDTH % LANES == 0);
            if (chk_stall) begin
                a_hold: assert (i_valid && (i_rows == chk_rows) && (i_last == chk_last));
            end
        end
    end
`endif
`endif

endmodule
